dvi_timing_gen: RTL and testbench
=================================

# dvi_timing_gen

Raster timing controller that sequences the three `tmds_encode` channels of the DVI output. It generates horizontal and vertical blanking, sync and display-enable, and pulls one 24-bit pixel per active cycle from the scanout FIFO over a valid/ready handshake. It presents per-channel `d`, `c` and `den` aligned for direct connection to the encoders. It sits between the framebuffer scanout FIFO and the encoders, in the pixel clock domain.

## Interface
- `H_ACTIVE`, default 640: active pixels per line
- `H_FRONT`, default 16: horizontal front porch cycles
- `H_SYNC`, default 96: hsync width
- `H_BACK`, default 48: horizontal back porch
- `V_ACTIVE`, default 480: active lines
- `V_FRONT`, default 10: vertical front porch lines
- `V_SYNC`, default 2: vsync lines
- `V_BACK`, default 33: vertical back porch lines
- `SYNC_POL`, default 0: asserted level of both hsync and vsync (0 = active-low)
- `UNDERFLOW_COLOUR`, default 24'hff00ff: RGB substituted on starvation (macro-dependent)
- `clk` in 1: pixel clock; the only clock
- `rst` in 1: synchronous, active-high reset
- `en` in 1: run request
- `pix_data` in 24: {R[23:16], G[15:8], B[7:0]}
- `pix_valid` in 1: FIFO has a pixel
- `pix_ready` out 1: pixel consumed this cycle if `pix_valid`
- `d_r`, `d_g`, `d_b` out 8 each: encoder data
- `c_b` out 2: {vsync, hsync} to blue encoder; red/green `c` are tied 0 externally
- `den` out 1: data enable to all encoders
- `frame_start` out 1: one-cycle pulse
- `underflow` out 1: sticky starvation flag
- `underflow_clr` in 1: clears `underflow`

## Operation
- Two FSMs, each with states ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - Horizontal FSM: down-counter loaded with (state length − 1). The state advances when the counter reaches 0.
  - Vertical FSM: identical structure. It advances only on the cycle the horizontal FSM leaves BACK.
  - Counters are 12 bits wide. All parameters must be ≥ 1. Total line length must be ≤ 4096.
- IDLE: entered from reset, and whenever a frame completes with `en` low.
  - Both FSMs are held at ACTIVE with counters loaded.
  - `pix_ready`=0; outputs show blanking with syncs deasserted.
- Leaving IDLE: `en` sampled high in IDLE → the next cycle is frame pixel (0,0).
- `en` low mid-frame: the frame runs to completion (end of vertical BACK), then the block enters IDLE. `en` high at that boundary → the next frame starts with no gap.
- `pix_ready` = running && h ACTIVE && v ACTIVE. It is decoded from state registers only, never from `pix_valid`.
- Starvation (`pix_ready` && !`pix_valid`):
  - `den` still asserts.
  - The pixel slot is filled per Configuration.
  - The raster never stalls.
- `pix_valid` outside active area: ignored; no transfer.
- hsync is asserted in h SYNC. vsync is asserted in v SYNC (whole lines, aligned to line start). Output level = `SYNC_POL` when asserted, ~`SYNC_POL` otherwise.
- `frame_start` pulses with the output cycle of pixel (0,0).

## Timing
- All outputs are registered, one cycle after the state they reflect. `den`, `d_*`, `c_b` and `frame_start` are mutually aligned.
  - The pixel accepted in cycle N appears on `d_*` with `den`=1 in cycle N+1.
- `pix_ready` is combinational from state; the transfer occurs on the same edge.
- Reset values:
  - `den`=0, `d_*`=0, `frame_start`=0, `underflow`=0, `pix_ready`=0.
  - `c_b`={~SYNC_POL, ~SYNC_POL}.
  - FSMs in IDLE.
- `rst` mid-frame: the next cycle shows reset values. No partial line is emitted afterwards.
- Frame period = (H_ACTIVE+H_FRONT+H_SYNC+H_BACK) × (V_ACTIVE+V_FRONT+V_SYNC+V_BACK) cycles. Defaults give 800 × 525.
- `d_*` during blanking = 0.

## Configuration
- `DVI_TIMING_UNDERFLOW_EN` defined:
  - A starved slot outputs `UNDERFLOW_COLOUR`.
  - `underflow` is set in the same cycle as the starved `den`, and stays set until `underflow_clr` or `rst`.
  - Set and clear in the same cycle → set wins.
- Not defined:
  - A starved slot outputs 0.
  - `underflow` is tied 0 and `underflow_clr` is ignored.

## Test plan
- Small raster (H 4/1/2/1, V 2/1/1/1, SYNC_POL 0), FIFO always valid, `en` held high:
  - `den` high for 4 of every 8 cycles on lines 0–1 only.
  - hsync low for exactly 2 cycles per line.
  - vsync low for exactly 8 cycles per 40-cycle frame.
  - `frame_start` every 40 cycles.
- Data ordering: feed an incrementing `pix_data` 0,1,2…
  - `d_b` shows 0..7 across the 8 active slots of frame 1, each one cycle after its acceptance.
- Starvation: drop `pix_valid` for pixel index 2.
  - With macro: slot shows ff00ff and `underflow` rises.
  - Without macro: slot shows 0 and `underflow` stays 0.
  - Pixel 3 is the next FIFO word in both cases.
- `en` dropped at cycle 10 of frame:
  - Frame completes (cycle 40); the block then idles with `pix_ready`=0 and syncs high.
  - Re-asserting `en` gives `frame_start` 2 cycles later.
- `rst` asserted mid-SYNC:
  - All outputs at reset values the next cycle.
  - After `rst` falls with `en` high, the first `den` follows 2 cycles later.
- Defaults:
  - Exactly 640 × 480 handshakes per 420000-cycle frame.
  - `pix_ready` never high while `den`-pipeline state is blanking.

Source files
------------

// File: rtl/dvi_timing_gen_if.sv
// Pixel stream from the scanout FIFO into the DVI raster timing generator.
interface dvi_timing_gen_if;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;

   modport master (output pix_data, pix_valid, input pix_ready);
   modport slave  (input pix_data, pix_valid, output pix_ready);
endinterface

// File: rtl/dvi_timing_gen.sv
// DVI raster timing: h/v blanking, syncs and den, pulls one pixel per active slot.
// Optional DVI_TIMING_UNDERFLOW_EN: starved slots show UNDERFLOW_COLOUR and set sticky underflow.
module dvi_timing_gen #(
   parameter int          H_ACTIVE         = 640,
   parameter int          H_FRONT          = 16,
   parameter int          H_SYNC           = 96,
   parameter int          H_BACK           = 48,
   parameter int          V_ACTIVE         = 480,
   parameter int          V_FRONT          = 10,
   parameter int          V_SYNC           = 2,
   parameter int          V_BACK           = 33,
   parameter bit          SYNC_POL         = 1'b0,
   parameter logic [23:0] UNDERFLOW_COLOUR = 24'hff00ff
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   dvi_timing_gen_if.slave  pix,
   output logic [7:0]       d_r,
   output logic [7:0]       d_g,
   output logic [7:0]       d_b,
   output logic [1:0]       c_b,
   output logic             den,
   output logic             frame_start,
   output logic             underflow,
   input  logic             underflow_clr
);

   typedef enum logic [1:0] {S_ACT, S_FRONT, S_SYNC, S_BACK} seg_t;

   localparam logic [11:0] HA_L = 12'(H_ACTIVE - 1);
   localparam logic [11:0] HF_L = 12'(H_FRONT - 1);
   localparam logic [11:0] HS_L = 12'(H_SYNC - 1);
   localparam logic [11:0] HB_L = 12'(H_BACK - 1);
   localparam logic [11:0] VA_L = 12'(V_ACTIVE - 1);
   localparam logic [11:0] VF_L = 12'(V_FRONT - 1);
   localparam logic [11:0] VS_L = 12'(V_SYNC - 1);
   localparam logic [11:0] VB_L = 12'(V_BACK - 1);

`ifdef DVI_TIMING_UNDERFLOW_EN
   localparam logic [23:0] STARVE_COLOUR = UNDERFLOW_COLOUR;
`else
   localparam logic [23:0] STARVE_COLOUR = 24'h0;
`endif

   logic        running, run_nxt;
   seg_t        h_st, h_nxt, v_st, v_nxt;
   logic [11:0] h_cnt, hc_nxt, v_cnt, vc_nxt;
   logic        line_end, frame_end;
   logic        hs_on, vs_on, first_pix, starved;

   always_comb begin
      run_nxt   = running;
      h_nxt     = h_st;
      hc_nxt    = h_cnt;
      v_nxt     = v_st;
      vc_nxt    = v_cnt;
      line_end  = 1'b0;
      frame_end = 1'b0;
      if (!running) begin
         h_nxt   = S_ACT;
         hc_nxt  = HA_L;
         v_nxt   = S_ACT;
         vc_nxt  = VA_L;
         run_nxt = en;
      end else begin
         if (h_cnt != 12'd0) hc_nxt = h_cnt - 12'd1;
         else begin
            case (h_st)
               S_ACT:   begin h_nxt = S_FRONT; hc_nxt = HF_L; end
               S_FRONT: begin h_nxt = S_SYNC;  hc_nxt = HS_L; end
               S_SYNC:  begin h_nxt = S_BACK;  hc_nxt = HB_L; end
               default: begin h_nxt = S_ACT;   hc_nxt = HA_L; line_end = 1'b1; end
            endcase
         end
         if (line_end) begin
            if (v_cnt != 12'd0) vc_nxt = v_cnt - 12'd1;
            else begin
               case (v_st)
                  S_ACT:   begin v_nxt = S_FRONT; vc_nxt = VF_L; end
                  S_FRONT: begin v_nxt = S_SYNC;  vc_nxt = VS_L; end
                  S_SYNC:  begin v_nxt = S_BACK;  vc_nxt = VB_L; end
                  default: begin v_nxt = S_ACT;   vc_nxt = VA_L; frame_end = 1'b1; end
               endcase
            end
         end
         // both FSMs wrap to loaded ACTIVE either way; en only decides whether we keep running
         if (frame_end) run_nxt = en;
      end
   end

   assign pix.pix_ready = running && (h_st == S_ACT) && (v_st == S_ACT);
   assign hs_on         = running && (h_st == S_SYNC);
   assign vs_on         = running && (v_st == S_SYNC);
   assign first_pix     = pix.pix_ready && (h_cnt == HA_L) && (v_cnt == VA_L);
   assign starved       = pix.pix_ready && !pix.pix_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         running         <= 1'b0;
         h_st            <= S_ACT;
         h_cnt           <= HA_L;
         v_st            <= S_ACT;
         v_cnt           <= VA_L;
         den             <= 1'b0;
         {d_r, d_g, d_b} <= 24'h0;
         c_b             <= {~SYNC_POL, ~SYNC_POL};
         frame_start     <= 1'b0;
      end else begin
         running     <= run_nxt;
         h_st        <= h_nxt;
         h_cnt       <= hc_nxt;
         v_st        <= v_nxt;
         v_cnt       <= vc_nxt;
         den         <= pix.pix_ready;
         c_b         <= {vs_on ? SYNC_POL : ~SYNC_POL, hs_on ? SYNC_POL : ~SYNC_POL};
         frame_start <= first_pix;
         if (!pix.pix_ready)    {d_r, d_g, d_b} <= 24'h0;
         else if (pix.pix_valid) {d_r, d_g, d_b} <= pix.pix_data;
         else                   {d_r, d_g, d_b} <= STARVE_COLOUR;
      end
   end

`ifdef DVI_TIMING_UNDERFLOW_EN
   always_ff @(posedge clk) begin
      if (rst)                underflow <= 1'b0;
      else if (starved)       underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
   end
`else
   logic unused_clr;
   assign unused_clr = underflow_clr ^ starved;
   assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench: small raster (8x5) on the main instance plus a 23x10 SYNC_POL=1 instance.
module tb_dvi_timing_gen;
`ifdef DVI_TIMING_UNDERFLOW_EN
   localparam logic [23:0] STARVE_EXP = 24'hff00ff;
   localparam bit          UF_ON      = 1'b1;
`else
   localparam logic [23:0] STARVE_EXP = 24'h0;
   localparam bit          UF_ON      = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, en, underflow_clr;
   logic [7:0] d_r, d_g, d_b;
   logic [1:0] c_b;
   logic den, frame_start, underflow;

   logic m_en = 1'b1, m_clr = 1'b0;
   logic [7:0] m_r, m_g, m_b;
   logic [1:0] m_cb;
   logic m_den, m_fs, m_uf;

   int n_chk = 0, n_fail = 0;
   int word_cnt = 0, exp_w = 0;
   bit uf_exp = 1'b0;
   int m_cyc = 0, m_hsk = 0, m_hs = 0, m_vs = 0, m_viol = 0, m_frames = 0;
   int m_period = 0, m_hsk_s = 0, m_hs_s = 0, m_vs_s = 0;
   bit m_have = 1'b0, m_prev_rdy = 1'b0;

   dvi_timing_gen_if pif();
   dvi_timing_gen_if mif();

   always #5 clk = ~clk;

   dvi_timing_gen #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) dut (
      .clk(clk), .rst(rst), .en(en), .pix(pif.slave),
      .d_r(d_r), .d_g(d_g), .d_b(d_b), .c_b(c_b), .den(den),
      .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr));

   dvi_timing_gen #(.H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)) dut_m (
      .clk(clk), .rst(rst), .en(m_en), .pix(mif.slave),
      .d_r(m_r), .d_g(m_g), .d_b(m_b), .c_b(m_cb), .den(m_den),
      .frame_start(m_fs), .underflow(m_uf), .underflow_clr(m_clr));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one cycle; FIFO models and the medium-raster observer update here
   task automatic tick();
      bit acc, acc2;
      acc  = pif.pix_ready && pif.pix_valid;
      acc2 = mif.pix_ready && mif.pix_valid;
      @(posedge clk); #1;
      if (acc) word_cnt++;
      pif.pix_data = 24'(word_cnt);
      if (rst) begin
         m_have = 1'b0; m_cyc = 0; m_hsk = 0; m_hs = 0; m_vs = 0; m_prev_rdy = 1'b0;
      end else begin
         if (m_fs) begin
            if (m_have) begin
               m_period = m_cyc; m_hsk_s = m_hsk; m_hs_s = m_hs; m_vs_s = m_vs; m_frames++;
            end
            m_have = 1'b1; m_cyc = 0; m_hsk = 0; m_hs = 0; m_vs = 0;
         end
         m_cyc++;
         if (acc2) m_hsk++;
         if (m_cb[0]) m_hs++;
         if (m_cb[1]) m_vs++;
         if (m_prev_rdy && !m_den) m_viol++;
         m_prev_rdy = mif.pix_ready;
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_den"}, den, 0);
      chk({tag, "_d"}, {d_r, d_g, d_b}, 0);
      chk({tag, "_fs"}, frame_start, 0);
      chk({tag, "_uf"}, underflow, 0);
      chk({tag, "_rdy"}, pif.pix_ready, 0);
      chk({tag, "_cb"}, c_b, 2'b11);
      chk({tag, "_mcb"}, m_cb, 2'b00);
   endtask

   // called at output cycle 0 of a frame (frame_start visible); leaves at cycle 40
   task automatic run_frame(input int starve, input int drop_at, input int clr_at);
      for (int k = 0; k < 40; k++) begin
         int line, col, p, j;
         bit den_e, rdy_e;
         logic [23:0] d_e;
         line  = k / 8;
         col   = k % 8;
         p     = k + 1;
         j     = line * 4 + col;
         den_e = (line < 2) && (col < 4);
         rdy_e = (k == 39) ? (drop_at < 0) : (((p / 8) < 2) && ((p % 8) < 4));
         d_e   = 24'h0;
         if (den_e) begin
            if (j == starve) begin
               d_e = STARVE_EXP;
               if (UF_ON) uf_exp = 1'b1;
            end else begin
               d_e = 24'(exp_w);
               exp_w++;
            end
         end
         chk($sformatf("den@%0d", k), den, den_e);
         chk($sformatf("fs@%0d", k), frame_start, k == 0);
         chk($sformatf("hs@%0d", k), c_b[0], !(col == 5 || col == 6));
         chk($sformatf("vs@%0d", k), c_b[1], line != 3);
         chk($sformatf("rdy@%0d", k), pif.pix_ready, rdy_e);
         chk($sformatf("data@%0d", k), {d_r, d_g, d_b}, d_e);
         chk($sformatf("uf@%0d", k), underflow, uf_exp);
         pif.pix_valid = !(k < 39 && rdy_e && ((p / 8) * 4 + (p % 8)) == starve);
         if (k == drop_at) en = 1'b0;
         underflow_clr = (k == clr_at);
         tick();
         if (k == clr_at) uf_exp = 1'b0;
      end
      underflow_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; underflow_clr = 1'b0;
      pif.pix_valid = 1'b1; pif.pix_data = 24'h0;
      mif.pix_valid = 1'b1; mif.pix_data = 24'h0;
      repeat (3) tick();
      chk_reset("rst0");

      // release with en high: IDLE, then pixel (0,0) state, then its output
      rst = 1'b0; en = 1'b1;
      chk("rel_rdy0", pif.pix_ready, 0);
      chk("rel_den0", den, 0);
      tick();
      chk("rel_rdy1", pif.pix_ready, 1);
      chk("rel_den1", den, 0);
      tick();
      chk("rel_den2", den, 1);
      chk("rel_fs2", frame_start, 1);

      run_frame(-1, -1, -1);
      run_frame(2, -1, -1);
      run_frame(-1, 10, 20);

      for (int i = 0; i < 4; i++) begin
         chk($sformatf("idle_rdy%0d", i), pif.pix_ready, 0);
         chk($sformatf("idle_den%0d", i), den, 0);
         chk($sformatf("idle_cb%0d", i), c_b, 2'b11);
         chk($sformatf("idle_fs%0d", i), frame_start, 0);
         chk($sformatf("idle_d%0d", i), {d_r, d_g, d_b}, 0);
         tick();
      end

      en = 1'b1;
      chk("re_rdy0", pif.pix_ready, 0);
      tick();
      chk("re_rdy1", pif.pix_ready, 1);
      chk("re_fs1", frame_start, 0);
      tick();
      chk("re_fs2", frame_start, 1);
      repeat (5) tick();
      chk("pre_rst_hs", c_b[0], 0);

      rst = 1'b1;
      tick();
      chk_reset("rst1");
      rst = 1'b0;
      chk("rst1_rdy0", pif.pix_ready, 0);
      tick();
      chk("rst1_den1", den, 0);
      chk("rst1_rdy1", pif.pix_ready, 1);
      tick();
      chk("rst1_den2", den, 1);
      chk("rst1_fs2", frame_start, 1);

      repeat (700) tick();
      chk("m_frames", m_frames > 0, 1);
      chk("m_period", m_period, 230);
      chk("m_hsk", m_hsk_s, 96);
      chk("m_hs_cnt", m_hs_s, 30);
      chk("m_vs_cnt", m_vs_s, 46);
      chk("m_rdy_blank", m_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
